// File: rtl/core_clk_rst_seq.sv
// Per-core clock/reset/PLL sequencer. Gates the core clock and holds the core
// in reset while the PLL feedback divider is reprogrammed, waits for a stable
// synchronised lock, then releases the core. Reports the locked divider and
// a sticky lock-timeout flag back to the CSR block.
module core_clk_rst_seq #(
  parameter int                  FB_DIV_WIDTH = 12,
  parameter logic [FB_DIV_WIDTH-1:0] FB_DIV_RESET = 12'd32,
  parameter int                  RST_HOLD     = 16,
  parameter int                  SETTLE       = 8,
  parameter int                  LOCK_TIMEOUT = 4096
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic [FB_DIV_WIDTH-1:0] fb_div_req_i,
  input  logic                    clk_en_req_i,
  input  logic                    arst_req_i,
  input  logic                    glob_arst_i,
  input  logic                    pll_locked_i,
  output logic [FB_DIV_WIDTH-1:0] pll_fb_div_o,
  output logic [FB_DIV_WIDTH-1:0] fb_div_actual_o,
  output logic                    locked_o,
  output logic                    lock_err_o,
  output logic                    core_clk_en_o,
  output logic                    core_arst_o
);

  localparam int CNT_MAX = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STB_W   = $clog2(SETTLE + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] SETTLE_LAST  = STB_W'(SETTLE - 1);

  typedef enum logic [1:0] {DRAIN, LOCK, RUN, HALT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [STB_W-1:0] stb;
  logic             lock_meta;
  logic             lock_s;
  // The first edge after async reset release acts as the DRAIN entry edge,
  // so the power-up drain lasts exactly RST_HOLD edges like any other drain.
  logic             boot;
  logic             div_change;

  // A non-zero request that differs from what the PLL already runs at.
  assign div_change = (fb_div_req_i != '0) && (fb_div_req_i != pll_fb_div_o);

  // Two-flop synchroniser for the asynchronous raw PLL lock.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked_i;
      lock_s    <= lock_meta;
    end
  end

  // Sequencer FSM with registered outputs; leaving RUN forces safe outputs.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state           <= DRAIN;
      cnt             <= '0;
      stb             <= '0;
      boot            <= 1'b1;
      pll_fb_div_o    <= FB_DIV_RESET;
      fb_div_actual_o <= '0;
      locked_o        <= 1'b0;
      lock_err_o      <= 1'b0;
      core_clk_en_o   <= 1'b0;
      core_arst_o     <= 1'b1;
    end else begin
      boot <= 1'b0;
      if (glob_arst_i) begin
        state           <= DRAIN;
        cnt             <= '0;
        stb             <= '0;
        lock_err_o      <= 1'b0;
        fb_div_actual_o <= '0;
        locked_o        <= 1'b0;
        core_clk_en_o   <= 1'b0;
        core_arst_o     <= 1'b1;
      end else begin
        case (state)
          DRAIN: begin
            if (boot) begin
              cnt <= '0;
            end else if (cnt == HOLD_LAST) begin
              state <= LOCK;
              cnt   <= '0;
              stb   <= '0;
              if (fb_div_req_i != '0) pll_fb_div_o <= fb_div_req_i;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          LOCK: begin
            if (lock_s && (stb == SETTLE_LAST)) begin
              state           <= RUN;
              cnt             <= '0;
              stb             <= '0;
              locked_o        <= 1'b1;
              fb_div_actual_o <= pll_fb_div_o;
              core_clk_en_o   <= clk_en_req_i;
              core_arst_o     <= arst_req_i;
            end else if (cnt == TIMEOUT_LAST) begin
              state      <= HALT;
              cnt        <= '0;
              stb        <= '0;
              lock_err_o <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
              stb <= lock_s ? stb + 1'b1 : '0;
            end
          end
          RUN: begin
            if (!lock_s || div_change) begin
              // Lock loss leaves the error flag alone; a divider change clears it.
              state           <= DRAIN;
              cnt             <= '0;
              stb             <= '0;
              if (lock_s) lock_err_o <= 1'b0;
              fb_div_actual_o <= '0;
              locked_o        <= 1'b0;
              core_clk_en_o   <= 1'b0;
              core_arst_o     <= 1'b1;
            end else begin
              core_clk_en_o <= clk_en_req_i;
              core_arst_o   <= arst_req_i;
            end
          end
          HALT: begin
            if (div_change) begin
              state      <= DRAIN;
              cnt        <= '0;
              stb        <= '0;
              lock_err_o <= 1'b0;
            end
          end
          default: begin
            state <= DRAIN;
            cnt   <= '0;
            stb   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_clk_rst_seq.sv
// Bench for core_clk_rst_seq: expectations are queued with the edge number at
// which they fall due and checked by a negedge monitor.
module tb_core_clk_rst_seq;

  logic        clk = 1'b0;
  logic        arst_ni;
  logic [11:0] fb_div_req;
  logic        clk_en_req;
  logic        arst_req;
  logic        glob_arst;
  logic        pll_locked;
  logic [11:0] pll_fb_div;
  logic [11:0] fb_div_actual;
  logic        locked;
  logic        lock_err;
  logic        core_clk_en;
  logic        core_arst;

  core_clk_rst_seq dut (
    .clk_i          (clk),
    .arst_ni        (arst_ni),
    .fb_div_req_i   (fb_div_req),
    .clk_en_req_i   (clk_en_req),
    .arst_req_i     (arst_req),
    .glob_arst_i    (glob_arst),
    .pll_locked_i   (pll_locked),
    .pll_fb_div_o   (pll_fb_div),
    .fb_div_actual_o(fb_div_actual),
    .locked_o       (locked),
    .lock_err_o     (lock_err),
    .core_clk_en_o  (core_clk_en),
    .core_arst_o    (core_arst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        locked;
    logic        err;
    logic        en;
    logic        rst;
    logic [11:0] div;
    logic [11:0] act;
  } out_t;

  typedef struct {
    int    due;
    string name;
    out_t  exp;
  } ent_t;

  ent_t sbq[$];
  ent_t pu[6];
  int   checks = 0;
  int   errors = 0;
  int   edge_n;
  int   k;

  // Edge index: 0 is the first rising edge after arst_ni releases.
  always @(posedge clk or negedge arst_ni)
    if (!arst_ni) edge_n <= -1;
    else          edge_n <= edge_n + 1;

  function automatic out_t mk(bit l, bit e, bit en, bit r, int d, int a);
    out_t o;
    o.locked = l;
    o.err    = e;
    o.en     = en;
    o.rst    = r;
    o.div    = d[11:0];
    o.act    = a[11:0];
    return o;
  endfunction

  function automatic ent_t ent(int due, string name, out_t exp);
    ent_t x;
    x.due  = due;
    x.name = name;
    x.exp  = exp;
    return x;
  endfunction

  task automatic cmp(string name, out_t exp);
    out_t got;
    got = {locked, lock_err, core_clk_en, core_arst, pll_fb_div, fb_div_actual};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got locked=%0b err=%0b en=%0b rst=%0b div=%0d act=%0d, want locked=%0b err=%0b en=%0b rst=%0b div=%0d act=%0d",
               name, edge_n, got.locked, got.err, got.en, got.rst, got.div, got.act,
               exp.locked, exp.err, exp.en, exp.rst, exp.div, exp.act);
    end
  endtask

  task automatic expect_at(int due, string name, out_t exp);
    sbq.push_back(ent(due, name, exp));
  endtask

  // Scoreboard monitor: pops every expectation that is due on this cycle.
  always @(negedge clk)
    if (arst_ni)
      while (sbq.size() > 0 && sbq[0].due <= edge_n) begin
        cmp(sbq[0].name, sbq[0].exp);
        sbq.delete(0);
      end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic goto_edge(int e);
    for (int i = 0; i < 20000 && edge_n < e; i++) step();
  endtask

  task automatic drain_q();
    for (int i = 0; i < 500 && sbq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    arst_ni    = 1'b0;
    fb_div_req = 12'd0;
    clk_en_req = 1'b1;
    arst_req   = 1'b0;
    glob_arst  = 1'b0;
    pll_locked = 1'b1;

    pu[0] = ent(0,  "pu_edge0",     mk(0, 0, 0, 1, 32, 0));
    pu[1] = ent(15, "pu_drain",     mk(0, 0, 0, 1, 32, 0));
    pu[2] = ent(16, "pu_lock",      mk(0, 0, 0, 1, 32, 0));
    pu[3] = ent(23, "pu_pre_run",   mk(0, 0, 0, 1, 32, 0));
    pu[4] = ent(24, "pu_run",       mk(1, 0, 1, 0, 32, 32));
    pu[5] = ent(30, "pu_run_hold",  mk(1, 0, 1, 0, 32, 32));

    #12;
    cmp("reset_state", mk(0, 0, 0, 1, 32, 0));

    // Power-up sequence
    @(negedge clk);
    arst_ni = 1'b1;
    for (int i = 0; i < 6; i++) sbq.push_back(pu[i]);
    goto_edge(32);

    // Zero and same-value requests keep RUN; core reset/enable follow requests
    k = edge_n;
    fb_div_req = 12'd0;
    arst_req   = 1'b1;
    expect_at(k + 1, "req0_arst_hi",   mk(1, 0, 1, 1, 32, 32));
    expect_at(k + 2, "same_arst_lo",   mk(1, 0, 1, 0, 32, 32));
    expect_at(k + 5, "same_stay_run",  mk(1, 0, 1, 0, 32, 32));
    step();
    fb_div_req = 12'd32;
    arst_req   = 1'b0;
    goto_edge(k + 5);
    clk_en_req = 1'b0;
    expect_at(k + 6, "clk_en_lo",      mk(1, 0, 0, 0, 32, 32));
    expect_at(k + 7, "clk_en_hi",      mk(1, 0, 1, 0, 32, 32));
    step();
    clk_en_req = 1'b1;
    goto_edge(k + 10);
    drain_q();

    // Divider change 32->50 with a 5-cycle lock drop during DRAIN
    k = edge_n;
    fb_div_req = 12'd50;
    expect_at(k + 1,  "div_drain",      mk(0, 0, 0, 1, 32, 0));
    expect_at(k + 16, "div_pre_load",   mk(0, 0, 0, 1, 32, 0));
    expect_at(k + 17, "div_loaded",     mk(0, 0, 0, 1, 50, 0));
    expect_at(k + 24, "div_pre_run",    mk(0, 0, 0, 1, 50, 0));
    expect_at(k + 25, "div_run",        mk(1, 0, 1, 0, 50, 50));
    step(2);
    pll_locked = 1'b0;
    step(5);
    pll_locked = 1'b1;
    goto_edge(k + 26);
    drain_q();

    // 3-cycle global reset in RUN, then a one-cycle lock glitch during LOCK
    k = edge_n;
    glob_arst = 1'b1;
    expect_at(k + 1,  "glob_drain",     mk(0, 0, 0, 1, 50, 0));
    expect_at(k + 19, "glob_lock",      mk(0, 0, 0, 1, 50, 0));
    expect_at(k + 28, "stb_cleared",    mk(0, 0, 0, 1, 50, 0));
    expect_at(k + 30, "stb_pre_run",    mk(0, 0, 0, 1, 50, 0));
    expect_at(k + 31, "glob_relock",    mk(1, 0, 1, 0, 50, 50));
    step(3);
    glob_arst = 1'b0;
    goto_edge(k + 20);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    goto_edge(k + 33);
    drain_q();

    // Lock loss in RUN: DRAIN three edges after the fall, error untouched
    k = edge_n;
    pll_locked = 1'b0;
    expect_at(k + 2, "loss_still_run",  mk(1, 0, 1, 0, 50, 50));
    expect_at(k + 3, "loss_drain",      mk(0, 0, 0, 1, 50, 0));
    step();
    pll_locked = 1'b1;
    goto_edge(k + 22);
    drain_q();

    // Asynchronous reset while in LOCK
    arst_ni = 1'b0;
    #1;
    cmp("arst_midlock", mk(0, 0, 0, 1, 32, 0));

    // Lock never arrives: timeout to HALT, then leave via a new divider
    pll_locked = 1'b0;
    fb_div_req = 12'd0;
    @(negedge clk);
    arst_ni = 1'b1;
    expect_at(16,   "to_lock_entry",   mk(0, 0, 0, 1, 32, 0));
    expect_at(4111, "to_pre_halt",     mk(0, 0, 0, 1, 32, 0));
    expect_at(4112, "to_halt",         mk(0, 1, 0, 1, 32, 0));
    goto_edge(4112);
    fb_div_req = 12'd32;
    expect_at(4114, "halt_same_req",   mk(0, 1, 0, 1, 32, 0));
    goto_edge(4115);
    fb_div_req = 12'd40;
    expect_at(4116, "halt_exit",       mk(0, 0, 0, 1, 32, 0));
    expect_at(4131, "halt_pre_load",   mk(0, 0, 0, 1, 32, 0));
    expect_at(4132, "halt_loaded",     mk(0, 0, 0, 1, 40, 0));
    goto_edge(4133);
    drain_q();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_clk_rst_seq.md
# core_clk_rst_seq

Per-core clock/reset/PLL sequencer, one instance per core, downstream of the SoC control CSR block. It turns the CSR's requested PLL feedback divider, clock enable and core reset into a safe sequence: gate the clock, hold reset, reprogram the PLL, wait for a stable lock, then release. It returns the divider actually locked and the synchronised lock status to the CSR block's read-only registers.

## Interface
Parameters:
- FB_DIV_WIDTH, 12: PLL feedback divider width.
- FB_DIV_RESET, 12'd32: divider driven to the PLL after reset.
- RST_HOLD, 16: cycles spent in DRAIN. Minimum 1.
- SETTLE, 8: consecutive synchronised-lock cycles required. Minimum 1.
- LOCK_TIMEOUT, 4096: maximum cycles in LOCK before an error. Must exceed SETTLE+2.

Ports:
- clk_i, in, 1: system clock.
- arst_ni, in, 1: reset, asynchronous assert, active-low.
- fb_div_req_i, in, FB_DIV_WIDTH: requested divider from the CSR. Value 0 means "no request".
- clk_en_req_i, in, 1: requested core clock enable.
- arst_req_i, in, 1: requested core reset, active-high.
- glob_arst_i, in, 1: software global reset, active-high, level.
- pll_locked_i, in, 1: raw PLL lock, asynchronous.
- pll_fb_div_o, out, FB_DIV_WIDTH: divider driven to the PLL.
- fb_div_actual_o, out, FB_DIV_WIDTH: last divider that reached RUN. Reads 0 when not running.
- locked_o, out, 1: 1 only in RUN.
- lock_err_o, out, 1: sticky lock-timeout flag.
- core_clk_en_o, out, 1: core clock-gate enable.
- core_arst_o, out, 1: core reset, active-high.

## Operation
- pll_locked_i passes through a 2-flop synchroniser (reset 0), producing lock_s.
- States are DRAIN, LOCK, RUN and HALT. There is one cycle counter (cnt), reset on every state entry, and a stable counter (stb).
- Reset values:
  - State is DRAIN, cnt=0, stb=0.
  - pll_fb_div_o=FB_DIV_RESET, fb_div_actual_o=0.
  - locked_o=0, lock_err_o=0.
  - core_clk_en_o=0, core_arst_o=1.
- Outputs outside RUN: core_clk_en_o=0, core_arst_o=1, locked_o=0, fb_div_actual_o=0.
- DRAIN:
  - cnt increments each cycle.
  - When cnt==RST_HOLD-1, the next edge enters LOCK.
  - On that same edge, pll_fb_div_o loads fb_div_req_i if it is non-zero; otherwise pll_fb_div_o is unchanged.
- LOCK:
  - cnt counts cycles in LOCK.
  - stb increments while lock_s=1 and clears to 0 when lock_s=0.
  - If stb==SETTLE-1 and lock_s=1, the next edge enters RUN. On that edge: locked_o<=1, fb_div_actual_o<=pll_fb_div_o, core_clk_en_o<=clk_en_req_i, core_arst_o<=arst_req_i.
  - Otherwise, if cnt==LOCK_TIMEOUT-1, the next edge enters HALT and sets lock_err_o<=1.
- RUN:
  - Each cycle, core_clk_en_o<=clk_en_req_i and core_arst_o<=arst_req_i.
  - If lock_s=0, go to DRAIN. This is lock loss; lock_err_o is not set.
  - Else, if fb_div_req_i!=0 and fb_div_req_i!=pll_fb_div_o, go to DRAIN.
- HALT:
  - Outputs are held in their safe values.
  - Exit to DRAIN only when fb_div_req_i!=0 and fb_div_req_i!=pll_fb_div_o.
- glob_arst_i=1 in any state:
  - Next state is DRAIN with cnt=0 and lock_err_o cleared.
  - The state stays in DRAIN (cnt held at 0) while glob_arst_i remains high.
  - pll_fb_div_o is not restored to FB_DIV_RESET.
- Every DRAIN entry caused by a divider change also clears lock_err_o.
- Priority in all states: glob_arst_i first, then lock loss, then divider change, then counter/timeout transitions.
- A request that changes during DRAIN: the value present on the DRAIN exit edge is the one loaded.
- A request equal to the current pll_fb_div_o, or equal to 0, never triggers a sequence.

## Timing
- Edge 0 is the first rising clk_i edge after arst_ni deasserts. Assertion of arst_ni takes effect immediately, mid-sequence included, forcing all reset values.
- The DRAIN→LOCK edge is edge RST_HOLD. pll_fb_div_o changes on exactly that edge.
- lock_s lags pll_locked_i by 2 edges.
- Minimum LOCK duration is SETTLE cycles. Best case, RUN is entered at edge RST_HOLD+SETTLE.
- In RUN, core_clk_en_o and core_arst_o follow their requests with 1 cycle of latency.
- The RUN→DRAIN edge drops core_clk_en_o to 0 and raises core_arst_o to 1 on the same edge.
- Lock loss: DRAIN is entered 3 edges after pll_locked_i falls (2 synchroniser edges plus 1 state edge).

## Test plan
- Power-up with pll_locked_i=1, fb_div_req_i=0, clk_en_req_i=1, arst_req_i=0:
  - pll_fb_div_o=32 throughout.
  - RUN entered at edge 24: locked_o=1, fb_div_actual_o=32, core_clk_en_o=1, core_arst_o=0.
- In RUN, fb_div_req_i changes 32→50 and pll_locked_i drops for 5 cycles, 2 cycles after the change:
  - DRAIN is entered: clk_en=0, rst=1, actual=0.
  - pll_fb_div_o=50 exactly 16 edges after entering DRAIN.
  - locked_o returns only after 8 consecutive lock_s=1 cycles; then fb_div_actual_o=50.
- pll_locked_i held 0 after reset:
  - HALT is entered at edge 16+4096 with lock_err_o=1.
  - fb_div_req_i=40 then causes DRAIN, lock_err_o=0, and pll_fb_div_o=40.
- glob_arst_i pulsed for 3 cycles while in RUN:
  - DRAIN is entered; core_arst_o=1 on the next edge.
  - Relock succeeds with the divider unchanged.
- arst_ni asserted mid-LOCK:
  - All outputs immediately take their reset values, including pll_fb_div_o=32.
- In RUN, fb_div_req_i=0 and then fb_div_req_i=pll_fb_div_o value:
  - No transition; locked_o stays 1.
  - arst_req_i toggles core_arst_o with 1 cycle of latency.
